// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display subsystem (arbiter and driver).
package seg7_pkg;

  // Arbiter ownership state.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } seg7_state_e;

  // Display width in hex digits; the driver is built with the same value.
  localparam int unsigned SEG7_WIDTH_NIBBLES = 6;

endpackage

// File: rtl/seg7_rr_pick.sv
// Combinational round-robin picker: first requester after `last`, wrapping,
// optionally skipping one index (the current owner during a forced handoff).
module seg7_rr_pick #(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned IDX_W       = $clog2(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [IDX_W-1:0]       last,
  input  logic                   exclude_valid,
  input  logic [IDX_W-1:0]       exclude_idx,
  output logic                   winner_valid,
  output logic [IDX_W-1:0]       winner_idx
);

  // Scan last+1 .. last+NUM_CLIENTS; the final offset lands back on `last`
  // so a lone requester that was granted last time can still win.
  always_comb begin
    int unsigned    cand;
    logic [IDX_W-1:0] cand_idx;
    cand         = 0;
    cand_idx     = '0;
    winner_valid = 1'b0;
    winner_idx   = '0;
    for (int unsigned off = 1; off <= NUM_CLIENTS; off++) begin
      cand     = (int'(last) + off) % NUM_CLIENTS;
      cand_idx = IDX_W'(cand);
      if (!winner_valid && req[cand_idx] && !(exclude_valid && (exclude_idx == cand_idx))) begin
        winner_valid = 1'b1;
        winner_idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/seg7_display_arbiter.sv
// Shares one 7-segment driver between several clients: round-robin grant with
// a minimum hold time, registered forwarding of the owner's data and masks.
module seg7_display_arbiter
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS   = 4,
  parameter int unsigned WIDTH_NIBBLES = SEG7_WIDTH_NIBBLES,
  parameter int unsigned HOLD_CYCLES   = 390625
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [NUM_CLIENTS-1:0]                 req,
  input  logic [NUM_CLIENTS*WIDTH_NIBBLES*4-1:0] client_data,
  input  logic [NUM_CLIENTS*WIDTH_NIBBLES-1:0]   client_digit_enable,
  input  logic [NUM_CLIENTS*WIDTH_NIBBLES-1:0]   client_dp_enable,
  output logic [NUM_CLIENTS-1:0]                 grant,
  output logic [WIDTH_NIBBLES*4-1:0]             data,
  output logic [WIDTH_NIBBLES-1:0]               digit_enable,
  output logic [WIDTH_NIBBLES-1:0]               decimal_point_enable
);

  localparam int unsigned IDX_W = $clog2(NUM_CLIENTS);
  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES) + 1;
  localparam int unsigned DW    = WIDTH_NIBBLES * 4;
  localparam int unsigned MW    = WIDTH_NIBBLES;

  localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] LastRst  = IDX_W'(NUM_CLIENTS - 1);

  seg7_state_e      state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;

  logic [NUM_CLIENTS-1:0] grant_d;
  logic [DW-1:0]          data_d;
  logic [MW-1:0]          digit_enable_d;
  logic [MW-1:0]          dp_enable_d;

  // Excluding the owner is only needed on expiry; on release its req is
  // already low, so one picker instance serves every transition.
  seg7_rr_pick #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .IDX_W       (IDX_W)
  ) u_rr_pick (
    .req           (req),
    .last          (last_q),
    .exclude_valid (state_q == OWNED),
    .exclude_idx   (owner_q),
    .winner_valid  (pick_valid),
    .winner_idx    (pick_idx)
  );

  // Ownership FSM next state: grant, release/handoff, hold countdown.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d    = OWNED;
          owner_d    = pick_idx;
          last_d     = pick_idx;
          hold_cnt_d = HoldLoad;
        end
      end
      OWNED: begin
        if (!req[owner_q]) begin
          // Release wins over expiry and is honoured at any counter value.
          if (pick_valid) begin
            owner_d    = pick_idx;
            last_d     = pick_idx;
            hold_cnt_d = HoldLoad;
          end else begin
            state_d = IDLE;
          end
        end else if (hold_cnt_q != '0) begin
          hold_cnt_d = hold_cnt_q - CNT_W'(1);
        end else if (pick_valid) begin
          owner_d    = pick_idx;
          last_d     = pick_idx;
          hold_cnt_d = HoldLoad;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output selection follows the owner being granted at this edge, so grant
  // and displayed content switch together.
  always_comb begin
    grant_d        = '0;
    data_d         = '0;
    digit_enable_d = '0;
    dp_enable_d    = '0;
    if (state_d == OWNED) begin
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
        if (owner_d == IDX_W'(i)) begin
          grant_d[i]     = 1'b1;
          data_d         = client_data[i*DW +: DW];
          digit_enable_d = client_digit_enable[i*MW +: MW];
          dp_enable_d    = client_dp_enable[i*MW +: MW];
        end
      end
    end
  end

  // State, counter and registered driver outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q              <= IDLE;
      owner_q              <= '0;
      last_q               <= LastRst;
      hold_cnt_q           <= '0;
      grant                <= '0;
      data                 <= '0;
      digit_enable         <= '0;
      decimal_point_enable <= '0;
    end else begin
      state_q              <= state_d;
      owner_q              <= owner_d;
      last_q               <= last_d;
      hold_cnt_q           <= hold_cnt_d;
      grant                <= grant_d;
      data                 <= data_d;
      digit_enable         <= digit_enable_d;
      decimal_point_enable <= dp_enable_d;
    end
  end

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Self-checking bench for seg7_display_arbiter (4 clients, hold of 4 cycles).
module tb_seg7_display_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned W    = 6;
  localparam int unsigned HOLD = 4;

  typedef struct {
    logic [N-1:0]   grant;
    logic [W*4-1:0] data;
    logic [W-1:0]   de;
    logic [W-1:0]   dp;
  } exp_t;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] grant;
    int           reps;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [N-1:0]     req;
  logic [N*W*4-1:0] client_data;
  logic [N*W-1:0]   client_digit_enable;
  logic [N*W-1:0]   client_dp_enable;
  logic [N-1:0]     grant;
  logic [W*4-1:0]   data;
  logic [W-1:0]     digit_enable;
  logic [W-1:0]     decimal_point_enable;

  logic [W*4-1:0] cdata [N];
  logic [W-1:0]   cde   [N];
  logic [W-1:0]   cdp   [N];

  exp_t sb[$];
  vec_t vecs[14];
  int   n_tests = 0;
  int   n_fail  = 0;

  seg7_display_arbiter #(
    .NUM_CLIENTS   (N),
    .WIDTH_NIBBLES (W),
    .HOLD_CYCLES   (HOLD)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .req                  (req),
    .client_data          (client_data),
    .client_digit_enable  (client_digit_enable),
    .client_dp_enable     (client_dp_enable),
    .grant                (grant),
    .data                 (data),
    .digit_enable         (digit_enable),
    .decimal_point_enable (decimal_point_enable)
  );

  always #5 clk = ~clk;

  always_comb begin
    client_data         = '0;
    client_digit_enable = '0;
    client_dp_enable    = '0;
    for (int i = 0; i < N; i++) begin
      client_data[i*W*4 +: W*4]     = cdata[i];
      client_digit_enable[i*W +: W] = cde[i];
      client_dp_enable[i*W +: W]    = cdp[i];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outputs for a given expected grant, using the content applied now.
  function automatic exp_t expect_for(input logic [N-1:0] g);
    exp_t e;
    e.grant = g;
    e.data  = '0;
    e.de    = '0;
    e.dp    = '0;
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        e.data = cdata[i];
        e.de   = cde[i];
        e.dp   = cdp[i];
      end
    end
    return e;
  endfunction

  task automatic compare_outputs(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, " scoreboard_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, " grant"}, 32'(grant), 32'(e.grant));
    check({tag, " data"}, 32'(data), 32'(e.data));
    check({tag, " digit_enable"}, 32'(digit_enable), 32'(e.de));
    check({tag, " dp_enable"}, 32'(decimal_point_enable), 32'(e.dp));
    check({tag, " grant_onehot"}, 32'($countones(grant) <= 1), 32'd1);
  endtask

  // Drive one cycle of req, queue the expectation, compare just after the edge.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] g, input string tag);
    req = r;
    sb.push_back(expect_for(g));
    @(posedge clk);
    #1;
    compare_outputs(tag);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " grant"}, 32'(grant), 32'd0);
    check({tag, " data"}, 32'(data), 32'd0);
    check({tag, " digit_enable"}, 32'(digit_enable), 32'd0);
    check({tag, " dp_enable"}, 32'(decimal_point_enable), 32'd0);
  endtask

  initial begin
    cdata[0] = 24'h10F0A1; cdata[1] = 24'h2233C4;
    cdata[2] = 24'h3E5D07; cdata[3] = 24'h4CAFE9;
    for (int i = 0; i < N; i++) begin
      cde[i] = 6'b111111 >> i;
      cdp[i] = 6'b000001 << i;
    end

    // Rotation, then early release, lone requester, release at expiry.
    vecs[0]  = '{req: 4'b1111, grant: 4'b0001, reps: 4};
    vecs[1]  = '{req: 4'b1111, grant: 4'b0010, reps: 4};
    vecs[2]  = '{req: 4'b1111, grant: 4'b0100, reps: 4};
    vecs[3]  = '{req: 4'b1111, grant: 4'b1000, reps: 4};
    vecs[4]  = '{req: 4'b1111, grant: 4'b0001, reps: 4};
    vecs[5]  = '{req: 4'b0000, grant: 4'b0000, reps: 1};
    vecs[6]  = '{req: 4'b0100, grant: 4'b0100, reps: 1};
    vecs[7]  = '{req: 4'b0101, grant: 4'b0100, reps: 1};
    vecs[8]  = '{req: 4'b0001, grant: 4'b0001, reps: 1};
    vecs[9]  = '{req: 4'b0000, grant: 4'b0000, reps: 1};
    vecs[10] = '{req: 4'b0010, grant: 4'b0010, reps: 20};
    vecs[11] = '{req: 4'b0000, grant: 4'b0000, reps: 1};
    vecs[12] = '{req: 4'b0100, grant: 4'b0100, reps: 4};
    vecs[13] = '{req: 4'b0000, grant: 4'b0000, reps: 1};

    reset_n = 1'b0;
    req     = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset_n = 1'b1;

    for (int v = 0; v < 14; v++) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        // Content change mid-ownership must appear one edge later.
        if (v == 10 && r == 10) cdata[1] = 24'h123456;
        step(vecs[v].req, vecs[v].grant, $sformatf("vec%0d.%0d", v, r));
      end
    end

    // Reset in the middle of a hold period.
    step(4'b0001, 4'b0001, "midhold0");
    step(4'b0001, 4'b0001, "midhold1");
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("async_reset");
    req = 4'b1010;
    @(posedge clk);
    #1;
    check_zero("held_reset");
    reset_n = 1'b1;
    // Client 1 first after reset, held for 4 cycles, then client 3.
    for (int r = 0; r < HOLD; r++) step(4'b1010, 4'b0010, $sformatf("post_reset%0d", r));
    step(4'b1010, 4'b1000, "post_reset_handoff");

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
